ex_flush_ctrl: RTL and testbench

Redirect and flush sequencer for the execute stage. It checks every control-flow or sequential instruction resolved in EX against the PC already fetched behind it. On a mismatch, a FENCE or a privileged jump it issues a one-cycle redirect and drives timed flush windows to the front end and to the pipeline. It replaces the ad-hoc flush counters in EX with one counter-based FSM and adds a mispredict counter.

---
 rtl/ex_flush_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ex_flush_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_flush_ctrl.sv
// ex_flush_ctrl: execute-stage redirect and flush sequencer.
// Compares each resolved instruction in EX against the PC fetched behind it.
// On a mispredict, FENCE or privileged jump it issues a one-cycle redirect and
// then holds timed flush windows to the front end and to the pipeline. A
// saturating counter records how many redirects have been issued.
module ex_flush_ctrl #(
   parameter int unsigned FE_FLUSH_CYCLES   = 4,
   parameter int unsigned PIPE_FLUSH_CYCLES = 6
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CACHE_READY,
   input  logic        BR_RESOLVE,
   input  logic        BR_TAKEN,
   input  logic [31:0] TARGET,
   input  logic        PRIV_JUMP,
   input  logic [31:0] PRIV_ADDR,
   input  logic        FENCE,
   input  logic        INSTR_VALID,
   input  logic [31:0] PC_EX,
   input  logic [31:0] PC_NEXT,
   output logic        REDIRECT,
   output logic [31:0] REDIRECT_ADDR,
   output logic        FLUSH_FE,
   output logic        FLUSH_PIPE,
   output logic        PREDICTED,
   output logic [31:0] MISPRED_CNT
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_FLUSH = 1'b1
   } state_t;

   localparam logic [3:0] FE_LOAD   = 4'(FE_FLUSH_CYCLES);
   localparam logic [3:0] PIPE_LOAD = 4'(PIPE_FLUSH_CYCLES);

   state_t      state_q, state_d;
   logic [1:0]  warm_q, warm_d;
   logic [3:0]  fe_cnt_q, fe_cnt_d;
   logic [3:0]  pipe_cnt_q, pipe_cnt_d;
   logic        redirect_q, redirect_d;
   logic [31:0] redirect_addr_q, redirect_addr_d;
   logic        flush_fe_q, flush_fe_d;
   logic        flush_pipe_q, flush_pipe_d;
   logic [31:0] mispred_cnt_q, mispred_cnt_d;

   logic [31:0] pc_ex_plus4;
   logic [31:0] expected_pc;
   logic        need_redirect;
   logic        eval_en;
   logic        detect;

   // Sequential successor of the EX instruction; wraps modulo 2^32.
   assign pc_ex_plus4 = PC_EX + 32'd4;

   // Evaluation is allowed only when idle, warmed up and the pipe advances.
   assign eval_en = (state_q == S_IDLE) && warm_q[1] && CACHE_READY;
   assign detect  = eval_en && need_redirect;

   // PREDICTED is a direct function of the PC compare, no register in the path.
   assign PREDICTED = ~detect;

   assign REDIRECT      = redirect_q;
   assign REDIRECT_ADDR = redirect_addr_q;
   assign FLUSH_FE      = flush_fe_q;
   assign FLUSH_PIPE    = flush_pipe_q;
   assign MISPRED_CNT   = mispred_cnt_q;

   // Prioritised choice of the expected successor PC and whether it was missed.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path leaves it unassigned, which would otherwise infer a latch.
      expected_pc   = '0;
      need_redirect = 1'b0;
      if (PRIV_JUMP) begin
         expected_pc   = PRIV_ADDR;
         need_redirect = 1'b1;
      end else if (FENCE) begin
         expected_pc   = pc_ex_plus4;
         need_redirect = 1'b1;
      end else if (BR_RESOLVE) begin
         expected_pc   = BR_TAKEN ? TARGET : pc_ex_plus4;
         need_redirect = (PC_NEXT != expected_pc);
      end else if (INSTR_VALID) begin
         expected_pc   = pc_ex_plus4;
         need_redirect = (PC_NEXT != expected_pc);
      end
   end

   // Next-state and registered-output computation for the IDLE/FLUSH sequencer.
   always_comb begin
      state_d         = state_q;
      warm_d          = warm_q;
      fe_cnt_d        = fe_cnt_q;
      pipe_cnt_d      = pipe_cnt_q;
      redirect_d      = redirect_q;
      redirect_addr_d = redirect_addr_q;
      flush_fe_d      = flush_fe_q;
      flush_pipe_d    = flush_pipe_q;
      mispred_cnt_d   = mispred_cnt_q;

      // With CACHE_READY low everything, including a pending pulse, holds.
      if (CACHE_READY) begin
         // Warm-up counter saturates and is never cleared by a later stall.
         if (warm_q != 2'd3) begin
            warm_d = warm_q + 2'd1;
         end

         case (state_q)
            S_IDLE: begin
               if (detect) begin
                  state_d         = S_FLUSH;
                  redirect_d      = 1'b1;
                  redirect_addr_d = expected_pc;
                  flush_fe_d      = 1'b1;
                  flush_pipe_d    = 1'b1;
                  fe_cnt_d        = FE_LOAD;
                  pipe_cnt_d      = PIPE_LOAD;
                  if (mispred_cnt_q != 32'hFFFF_FFFF) begin
                     mispred_cnt_d = mispred_cnt_q + 32'd1;
                  end
               end
            end

            S_FLUSH: begin
               redirect_d = 1'b0;
               if (fe_cnt_q != 4'd0) begin
                  fe_cnt_d = fe_cnt_q - 4'd1;
               end
               if (pipe_cnt_q != 4'd0) begin
                  pipe_cnt_d = pipe_cnt_q - 4'd1;
               end
               if (fe_cnt_q == 4'd1) begin
                  flush_fe_d = 1'b0;
               end
               if (pipe_cnt_q == 4'd1) begin
                  flush_pipe_d = 1'b0;
                  state_d      = S_IDLE;
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      // NOTE: state flops use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      if (!RST) begin
         state_q         <= S_IDLE;
         warm_q          <= 2'd0;
         fe_cnt_q        <= 4'd0;
         pipe_cnt_q      <= 4'd0;
         redirect_q      <= 1'b0;
         redirect_addr_q <= 32'd0;
         flush_fe_q      <= 1'b0;
         flush_pipe_q    <= 1'b0;
         mispred_cnt_q   <= 32'd0;
      end else begin
         state_q         <= state_d;
         warm_q          <= warm_d;
         fe_cnt_q        <= fe_cnt_d;
         pipe_cnt_q      <= pipe_cnt_d;
         redirect_q      <= redirect_d;
         redirect_addr_q <= redirect_addr_d;
         flush_fe_q      <= flush_fe_d;
         flush_pipe_q    <= flush_pipe_d;
         mispred_cnt_q   <= mispred_cnt_d;
      end
   end

endmodule

// File: tb/tb_ex_flush_ctrl.sv
// tb_ex_flush_ctrl: directed stimulus with a redirect scoreboard.
// The stimulus process pushes the expected redirect (address, count and flush
// window lengths) when it applies a vector; a monitor on the falling edge pops
// and compares whenever a new REDIRECT pulse appears.
module tb_ex_flush_ctrl;

   logic        CLK;
   logic        RST;
   logic        CACHE_READY;
   logic        BR_RESOLVE;
   logic        BR_TAKEN;
   logic [31:0] TARGET;
   logic        PRIV_JUMP;
   logic [31:0] PRIV_ADDR;
   logic        FENCE;
   logic        INSTR_VALID;
   logic [31:0] PC_EX;
   logic [31:0] PC_NEXT;
   logic        REDIRECT;
   logic [31:0] REDIRECT_ADDR;
   logic        FLUSH_FE;
   logic        FLUSH_PIPE;
   logic        PREDICTED;
   logic [31:0] MISPRED_CNT;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] cnt;
      int          fe_len;
      int          pipe_len;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] exp_cnt;
   int          n_vec;
   int          n_err;

   ex_flush_ctrl #(
      .FE_FLUSH_CYCLES   (4),
      .PIPE_FLUSH_CYCLES (6)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .CACHE_READY   (CACHE_READY),
      .BR_RESOLVE    (BR_RESOLVE),
      .BR_TAKEN      (BR_TAKEN),
      .TARGET        (TARGET),
      .PRIV_JUMP     (PRIV_JUMP),
      .PRIV_ADDR     (PRIV_ADDR),
      .FENCE         (FENCE),
      .INSTR_VALID   (INSTR_VALID),
      .PC_EX         (PC_EX),
      .PC_NEXT       (PC_NEXT),
      .REDIRECT      (REDIRECT),
      .REDIRECT_ADDR (REDIRECT_ADDR),
      .FLUSH_FE      (FLUSH_FE),
      .FLUSH_PIPE    (FLUSH_PIPE),
      .PREDICTED     (PREDICTED),
      .MISPRED_CNT   (MISPRED_CNT)
   );

   // 10 ns clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // One comparison: counts it and reports a miscompare.
   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      BR_RESOLVE  = 1'b0;
      BR_TAKEN    = 1'b0;
      TARGET      = '0;
      PRIV_JUMP   = 1'b0;
      PRIV_ADDR   = '0;
      FENCE       = 1'b0;
      INSTR_VALID = 1'b0;
      PC_EX       = '0;
      PC_NEXT     = '0;
   endtask

   task automatic idle(input int n);
      clear_inputs();
      repeat (n) cyc();
   endtask

   // Apply one EX vector for one cycle; check PREDICTED and queue any redirect.
   task automatic vec(input string name,
                      input logic priv, input logic [31:0] paddr, input logic fence,
                      input logic br, input logic taken, input logic [31:0] tgt,
                      input logic iv, input logic [31:0] pc_ex, input logic [31:0] pc_next,
                      input logic exp_pred, input logic [31:0] exp_addr,
                      input int fe_len, input int pipe_len);
      exp_t e;
      PRIV_JUMP   = priv;
      PRIV_ADDR   = paddr;
      FENCE       = fence;
      BR_RESOLVE  = br;
      BR_TAKEN    = taken;
      TARGET      = tgt;
      INSTR_VALID = iv;
      PC_EX       = pc_ex;
      PC_NEXT     = pc_next;
      #1;
      check({name, "_predicted"}, {31'd0, PREDICTED}, {31'd0, exp_pred});
      if (!exp_pred) begin
         if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
         e.addr     = exp_addr;
         e.cnt      = exp_cnt;
         e.fe_len   = fe_len;
         e.pipe_len = pipe_len;
         exp_q.push_back(e);
      end
      cyc();
      clear_inputs();
   endtask

   // Monitor: pops on each new REDIRECT pulse and measures the flush windows.
   initial begin
      exp_t cur;
      logic prev_red;
      logic fe_run, pipe_run;
      int   fe_n, pipe_n;
      prev_red = 1'b0;
      fe_run   = 1'b0;
      pipe_run = 1'b0;
      fe_n     = 0;
      pipe_n   = 0;
      cur      = '{addr: '0, cnt: '0, fe_len: 0, pipe_len: 0};
      forever begin
         @(negedge CLK);
         if (REDIRECT && !prev_red) begin
            if (exp_q.size() == 0) begin
               check("unexpected_redirect", REDIRECT_ADDR, 32'hDEAD_BEEF);
            end else begin
               cur = exp_q.pop_front();
               check("redirect_addr", REDIRECT_ADDR, cur.addr);
               check("mispred_cnt", MISPRED_CNT, cur.cnt);
               check("flush_fe_rise", {31'd0, FLUSH_FE}, 32'd1);
               fe_run   = 1'b1;
               pipe_run = 1'b1;
               fe_n     = 0;
               pipe_n   = 0;
            end
         end
         if (!RST) begin
            // A reset truncates the windows; their length is not meaningful.
            fe_run   = 1'b0;
            pipe_run = 1'b0;
         end else begin
            if (fe_run) begin
               if (FLUSH_FE) fe_n++;
               else begin
                  check("flush_fe_len", fe_n, cur.fe_len);
                  fe_run = 1'b0;
               end
            end
            if (pipe_run) begin
               if (FLUSH_PIPE) pipe_n++;
               else begin
                  check("flush_pipe_len", pipe_n, cur.pipe_len);
                  pipe_run = 1'b0;
               end
            end
         end
         prev_red = REDIRECT;
      end
   end

   // Directed stimulus.
   initial begin
      n_vec       = 0;
      n_err       = 0;
      exp_cnt     = '0;
      RST         = 1'b0;
      CACHE_READY = 1'b1;
      clear_inputs();

      // Reset held for three edges.
      repeat (3) cyc();
      check("rst_redirect", {31'd0, REDIRECT}, 32'd0);
      check("rst_addr", REDIRECT_ADDR, 32'd0);
      check("rst_flush_fe", {31'd0, FLUSH_FE}, 32'd0);
      check("rst_flush_pipe", {31'd0, FLUSH_PIPE}, 32'd0);
      check("rst_cnt", MISPRED_CNT, 32'd0);
      check("rst_predicted", {31'd0, PREDICTED}, 32'd1);
      RST = 1'b1;

      // Warm-up: first two cycles suppressed, third evaluates.
      vec("warm1", 0, 0, 0, 0, 0, 0, 1, 32'h100, 32'h200, 1, 0, 0, 0);
      vec("warm2", 0, 0, 0, 0, 0, 0, 1, 32'h100, 32'h200, 1, 0, 0, 0);
      vec("warm3", 0, 0, 0, 0, 0, 0, 1, 32'h100, 32'h200, 0, 32'h104, 4, 6);
      idle(8);

      // Correct predictions: taken, not-taken, sequential.
      vec("br_taken_ok", 0, 0, 0, 1, 1, 32'h2000, 0, 32'h1000, 32'h2000, 1, 0, 0, 0);
      vec("br_ntaken_ok", 0, 0, 0, 1, 0, 32'h2000, 0, 32'h1000, 32'h1004, 1, 0, 0, 0);
      vec("seq_ok", 0, 0, 0, 0, 0, 0, 1, 32'h1004, 32'h1008, 1, 0, 0, 0);
      check("cnt_after_ok", MISPRED_CNT, exp_cnt);
      check("no_flush_after_ok", {30'd0, FLUSH_FE, FLUSH_PIPE}, 32'd0);

      // Taken mispredict, then inputs during FLUSH, then back-to-back redirect.
      vec("br_taken_miss", 0, 0, 0, 1, 1, 32'h2000, 0, 32'h1000, 32'h1004, 0, 32'h2000, 4, 6);
      for (int i = 0; i < 6; i++)
         vec("in_flush", 0, 0, 0, 0, 0, 0, 1, 32'h40, 32'h80, 1, 0, 0, 0);
      vec("back_to_back", 0, 0, 0, 0, 0, 0, 1, 32'h40, 32'h80, 0, 32'h44, 4, 6);
      idle(8);

      // Priority: PRIV_JUMP over FENCE over a mispredicting branch.
      vec("prio_priv", 1, 32'h8000_0000, 1, 1, 1, 32'h3000, 1, 32'h1000, 32'h1004, 0, 32'h8000_0000, 4, 6);
      idle(8);
      // FENCE redirects even when PC_NEXT already matches PC_EX+4.
      vec("prio_fence", 0, 0, 1, 1, 1, 32'h3000, 0, 32'h500, 32'h504, 0, 32'h504, 4, 6);
      idle(8);
      // Branch outcome beats the sequential check.
      vec("prio_br", 0, 0, 0, 1, 0, 32'h9000, 1, 32'h600, 32'h604, 1, 0, 0, 0);

      // Stall three cycles inside FLUSH: windows stretch to 7 and 9.
      vec("stall_miss", 0, 0, 0, 0, 0, 0, 1, 32'h700, 32'h800, 0, 32'h704, 7, 9);
      vec("stall_f1", 0, 0, 0, 0, 0, 0, 1, 32'h700, 32'h800, 1, 0, 0, 0);
      CACHE_READY = 1'b0;
      for (int i = 0; i < 3; i++)
         vec("stall_frozen", 0, 0, 0, 0, 0, 0, 1, 32'h700, 32'h800, 1, 0, 0, 0);
      CACHE_READY = 1'b1;
      idle(10);

      // Address wrap.
      vec("fence_wrap", 0, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 0, 32'h0000_0000, 4, 6);
      idle(8);
      vec("br_wrap_ok", 0, 0, 0, 1, 0, 32'h10, 0, 32'hFFFF_FFFC, 32'h0, 1, 0, 0, 0);

      // Counter saturation.
      force dut.mispred_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.mispred_cnt_q;
      exp_cnt = 32'hFFFF_FFFF;
      cyc();
      check("cnt_preset", MISPRED_CNT, 32'hFFFF_FFFF);
      vec("sat_miss", 0, 0, 0, 0, 0, 0, 1, 32'h40, 32'h80, 0, 32'h44, 4, 6);
      idle(8);
      check("cnt_saturated", MISPRED_CNT, 32'hFFFF_FFFF);

      // Reset mid-FLUSH clears everything and restarts warm-up.
      vec("rst_miss", 0, 0, 0, 0, 0, 0, 1, 32'h900, 32'h0, 0, 32'h904, 4, 6);
      RST = 1'b0;
      cyc();
      exp_cnt = '0;
      check("midrst_redirect", {31'd0, REDIRECT}, 32'd0);
      check("midrst_addr", REDIRECT_ADDR, 32'd0);
      check("midrst_flush", {30'd0, FLUSH_FE, FLUSH_PIPE}, 32'd0);
      check("midrst_cnt", MISPRED_CNT, 32'd0);
      RST = 1'b1;
      // Warm-up counts only edges with CACHE_READY high.
      vec("rewarm1", 0, 0, 0, 0, 0, 0, 1, 32'h900, 32'h0, 1, 0, 0, 0);
      CACHE_READY = 1'b0;
      vec("rewarm_stall", 0, 0, 0, 0, 0, 0, 1, 32'h900, 32'h0, 1, 0, 0, 0);
      CACHE_READY = 1'b1;
      vec("rewarm2", 0, 0, 0, 0, 0, 0, 1, 32'h900, 32'h0, 1, 0, 0, 0);
      vec("rewarm3", 0, 0, 0, 0, 0, 0, 1, 32'h900, 32'h0, 0, 32'h904, 4, 6);
      idle(10);

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
